mc_control_unit: RTL and testbench

//  Multi-cycle control FSM for the RV32I-subset core; the issuing end of the ALU op interface.

---
 rtl/mc_control_unit_pkg.sv | 49 ++++
 rtl/mc_control_unit_if.sv | 30 +++
 rtl/mc_control_unit_alu_op_decoder.sv | 75 +++++++
 rtl/mc_control_unit.sv | 186 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared constants for the multi-cycle RV32I-subset control unit:
// ALU op encodings, opcodes, immediate selects and the controller state enum.
package riscv_ctrl_pkg;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_SLT = 4'b0100;
    localparam logic [3:0] ALUOP_XOR = 4'b0101;
    localparam logic [3:0] ALUOP_LSR = 4'b1000;
    localparam logic [3:0] ALUOP_LSL = 4'b1001;
    localparam logic [3:0] ALUOP_ASR = 4'b1010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_ALU   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_WB_MEM   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_TRAP     = 4'd10
    } ctrl_state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] word);
        return word[6:0];
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath/memory bundle. master = control unit, slave = datapath side.
interface mc_control_unit_if;
    logic [31:0] instr;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [1:0]  imm_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_write;
    logic        wb_sel;

    modport master (
        input  instr, zero, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_imm,
               imm_sel, dmem_req, dmem_we, reg_write, wb_sel
    );

    modport slave (
        output instr, zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_imm,
               imm_sel, dmem_req, dmem_we, reg_write, wb_sel
    );
endinterface

// File: rtl/mc_control_unit_alu_op_decoder.sv
// Combinational {opcode, funct3, funct7} -> ALU op plus legality, shared by
// register-register and register-immediate arithmetic.
module alu_op_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_op_o,
    output logic       legal_o
);
    logic is_r;
    logic is_i;
    logic f7_base;
    logic f7_alt;
    logic f7_ok;

    assign is_r    = (opcode_i == OPC_OP);
    assign is_i    = (opcode_i == OPC_OP_IMM);
    assign f7_base = (funct7_i == F7_BASE);
    assign f7_alt  = (funct7_i == F7_ALT);
    // Immediate forms carry imm bits in funct7, so only shifts constrain it there.
    assign f7_ok   = is_i || f7_base;

    always_comb begin
        alu_op_o = ALUOP_ADD;
        legal_o  = 1'b0;
        if (is_r || is_i) begin
            case (funct3_i)
                3'b000: begin
                    if (f7_ok) begin
                        alu_op_o = ALUOP_ADD;
                        legal_o  = 1'b1;
                    end else if (is_r && f7_alt) begin
                        alu_op_o = ALUOP_SUB;
                        legal_o  = 1'b1;
                    end
                end
                3'b111: begin
                    alu_op_o = ALUOP_AND;
                    legal_o  = f7_ok;
                end
                3'b110: begin
                    alu_op_o = ALUOP_OR;
                    legal_o  = f7_ok;
                end
                3'b100: begin
                    alu_op_o = ALUOP_XOR;
                    legal_o  = f7_ok;
                end
                3'b010: begin
                    alu_op_o = ALUOP_SLT;
                    legal_o  = f7_ok;
                end
                3'b001: begin
                    alu_op_o = ALUOP_LSL;
                    legal_o  = f7_base;
                end
                3'b101: begin
                    if (f7_base) begin
                        alu_op_o = ALUOP_LSR;
                        legal_o  = 1'b1;
                    end else if (f7_alt) begin
                        alu_op_o = ALUOP_ASR;
                        legal_o  = 1'b1;
                    end
                end
                default: begin
                    alu_op_o = ALUOP_ADD;
                    legal_o  = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing.
// Define ILLEGAL_TRAP_EN to send illegal instructions to a sticky TRAP state (adds illegal_instr).
module mc_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mc_control_unit_if.master    bus,
    output logic [INSTRET_W-1:0] instret,
`ifdef ILLEGAL_TRAP_EN
    output logic                 illegal_instr,
`endif
    output logic [3:0]           state_dbg
);
    ctrl_state_e          state_q, state_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] dec_alu_op;
    logic       dec_legal;
    logic       unused_instr_bits;

    logic       imem_req, ir_write, pc_write, pc_src;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic [1:0] imm_sel;
    logic       dmem_req, dmem_we, reg_write, wb_sel;
    logic       retire;

    assign opcode            = opcode_of(bus.instr);
    assign funct3            = bus.instr[14:12];
    assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

    alu_op_decoder u_alu_op_decoder (
        .opcode_i (opcode),
        .funct3_i (funct3),
        .funct7_i (bus.instr[31:25]),
        .alu_op_o (dec_alu_op),
        .legal_o  (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instret_d   = instret_q;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_op      = ALUOP_AND;
        alu_src_imm = 1'b0;
        imm_sel     = IMM_I;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = 1'b0;
        retire      = 1'b0;

        // Reset silences every strobe so a pending memory access is dropped at once.
        if (rst) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (opcode == OPC_OP && dec_legal) begin
                        state_d = ST_EXEC_R;
                    end else if (opcode == OPC_OP_IMM && dec_legal) begin
                        state_d = ST_EXEC_I;
                    end else if ((opcode == OPC_LOAD || opcode == OPC_STORE) && funct3 == F3_WORD) begin
                        state_d = ST_MEM_ADDR;
                    end else if (opcode == OPC_BRANCH && funct3 == F3_BEQ) begin
                        state_d = ST_BRANCH;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = ST_TRAP;
`else
                        state_d = ST_FETCH;
                        retire  = 1'b1;
`endif
                    end
                end
                ST_EXEC_R: begin
                    alu_op  = dec_alu_op;
                    state_d = ST_WB_ALU;
                end
                ST_EXEC_I: begin
                    alu_op      = dec_alu_op;
                    alu_src_imm = 1'b1;
                    imm_sel     = IMM_I;
                    state_d     = ST_WB_ALU;
                end
                ST_WB_ALU: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_MEM_ADDR: begin
                    alu_op      = ALUOP_ADD;
                    alu_src_imm = 1'b1;
                    imm_sel     = (opcode == OPC_STORE) ? IMM_S : IMM_I;
                    state_d     = (opcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD: begin
                    dmem_req = 1'b1;
                    if (bus.dmem_ready) begin
                        state_d = ST_WB_MEM;
                    end
                end
                ST_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_sel    = 1'b1;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_MEM_WR: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                    if (bus.dmem_ready) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_BRANCH: begin
                    alu_op  = ALUOP_SUB;
                    imm_sel = IMM_B;
                    if (bus.zero) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    state_d = ST_TRAP;
                end
`endif
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end

        if (retire) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.ir_write    = ir_write;
    assign bus.pc_write    = pc_write;
    assign bus.pc_src      = pc_src;
    assign bus.alu_op      = alu_op;
    assign bus.alu_src_imm = alu_src_imm;
    assign bus.imm_sel     = imm_sel;
    assign bus.dmem_req    = dmem_req;
    assign bus.dmem_we     = dmem_we;
    assign bus.reg_write   = reg_write;
    assign bus.wb_sel      = wb_sel;

    assign instret   = rst ? '0 : instret_q;
    assign state_dbg = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state_q == ST_TRAP) && !rst;
`endif
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: each step queues the expected state/strobes/instret
// and pops it against the DUT on the falling edge.
module tb_mc_control_unit;
    import riscv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instret;
    logic [3:0]  state_dbg;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_instr;
`endif

    always #5 clk = ~clk;

    mc_control_unit_if bus ();

    mc_control_unit #(.INSTRET_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .instret       (instret),
`ifdef ILLEGAL_TRAP_EN
        .illegal_instr (illegal_instr),
`endif
        .state_dbg     (state_dbg)
    );

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [31:0] ir;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_ir = 32'd0;

    // {imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_imm, imm_sel, dmem_req, dmem_we, reg_write, wb_sel}
    function automatic logic [14:0] cv(input logic imem, input logic irw, input logic pcw, input logic pcs,
                                       input logic [3:0] op, input logic src, input logic [1:0] is,
                                       input logic dreq, input logic dwe, input logic rw, input logic wbs);
        return {imem, irw, pcw, pcs, op, src, is, dreq, dwe, rw, wbs};
    endfunction

    logic [14:0] ctl_obs;
    assign ctl_obs = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_op, bus.alu_src_imm,
                      bus.imm_sel, bus.dmem_req, bus.dmem_we, bus.reg_write, bus.wb_sel};

    localparam logic [14:0] C_IDLE = 15'd0;

    task automatic check_front();
        exp_t e;
        e = sb.pop_front();
        $display("step %-12s state=%0d ctl=%h instret=%0d", e.tag, state_dbg, ctl_obs, instret);
        n_cmp++;
        assert (state_dbg === e.st) else begin
            n_bad++;
            $error("FAIL %s state got=%0d want=%0d", e.tag, state_dbg, e.st);
        end
        n_cmp++;
        assert (ctl_obs === e.ctl) else begin
            n_bad++;
            $error("FAIL %s ctl got=%h want=%h", e.tag, ctl_obs, e.ctl);
        end
        n_cmp++;
        assert (instret === e.ir) else begin
            n_bad++;
            $error("FAIL %s instret got=%0d want=%0d", e.tag, instret, e.ir);
        end
`ifdef ILLEGAL_TRAP_EN
        n_cmp++;
        assert (illegal_instr === e.ill) else begin
            n_bad++;
            $error("FAIL %s illegal_instr got=%b want=%b", e.tag, illegal_instr, e.ill);
        end
`endif
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [14:0] ctl, input logic ill = 1'b0);
        exp_t e;
        e.tag = tag; e.st = st; e.ctl = ctl; e.ir = exp_ir; e.ill = ill;
        sb.push_back(e);
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [31:0] word);
        bus.instr      = word;
        bus.imem_ready = 1'b1;
        step({tag, ":F"}, ST_FETCH, cv(1, 1, 1, 0, ALUOP_AND, 0, IMM_I, 0, 0, 0, 0));
        bus.imem_ready = 1'b0;
        step({tag, ":D"}, ST_DECODE, C_IDLE);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] word, input logic is_imm, input logic [3:0] op);
        fetch_decode(tag, word);
        if (is_imm) step({tag, ":X"}, ST_EXEC_I, cv(0, 0, 0, 0, op, 1, IMM_I, 0, 0, 0, 0));
        else        step({tag, ":X"}, ST_EXEC_R, cv(0, 0, 0, 0, op, 0, IMM_I, 0, 0, 0, 0));
        step({tag, ":W"}, ST_WB_ALU, cv(0, 0, 0, 0, ALUOP_AND, 0, IMM_I, 0, 0, 1, 0));
        exp_ir++;
    endtask

    initial begin
        rst            = 1'b1;
        bus.instr      = 32'h0000_0013;
        bus.zero       = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("reset", ST_FETCH, C_IDLE);
        rst = 1'b0;

        // Fetch stall: request held, no latch strobes.
        step("add:Fwait", ST_FETCH, cv(1, 0, 0, 0, ALUOP_AND, 0, IMM_I, 0, 0, 0, 0));
        run_alu("add",  32'h0020_81B3, 1'b0, ALUOP_ADD);
        run_alu("sub",  32'h4020_81B3, 1'b0, ALUOP_SUB);
        run_alu("sra",  32'h4020_D1B3, 1'b0, ALUOP_ASR);
        run_alu("slti", 32'h0050_A193, 1'b1, ALUOP_SLT);
        run_alu("srai", 32'h4030_D193, 1'b1, ALUOP_ASR);

        // lw with three wait cycles on the data port.
        fetch_decode("lw", 32'h0000_A183);
        step("lw:A", ST_MEM_ADDR, cv(0, 0, 0, 0, ALUOP_ADD, 1, IMM_I, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step("lw:Rwait", ST_MEM_RD, cv(0, 0, 0, 0, ALUOP_AND, 0, IMM_I, 1, 0, 0, 0));
        bus.dmem_ready = 1'b1;
        step("lw:R", ST_MEM_RD, cv(0, 0, 0, 0, ALUOP_AND, 0, IMM_I, 1, 0, 0, 0));
        bus.dmem_ready = 1'b0;
        step("lw:W", ST_WB_MEM, cv(0, 0, 0, 0, ALUOP_AND, 0, IMM_I, 0, 0, 1, 1));
        exp_ir++;

        fetch_decode("sw", 32'h0020_A023);
        step("sw:A", ST_MEM_ADDR, cv(0, 0, 0, 0, ALUOP_ADD, 1, IMM_S, 0, 0, 0, 0));
        bus.dmem_ready = 1'b1;
        step("sw:M", ST_MEM_WR, cv(0, 0, 0, 0, ALUOP_AND, 0, IMM_I, 1, 1, 0, 0));
        bus.dmem_ready = 1'b0;
        exp_ir++;

        bus.zero = 1'b1;
        fetch_decode("beq1", 32'h0020_8063);
        step("beq1:B", ST_BRANCH, cv(0, 0, 1, 1, ALUOP_SUB, 0, IMM_B, 0, 0, 0, 0));
        exp_ir++;
        bus.zero = 1'b0;
        fetch_decode("beq0", 32'h0020_8063);
        step("beq0:B", ST_BRANCH, cv(0, 0, 0, 0, ALUOP_SUB, 0, IMM_B, 0, 0, 0, 0));
        exp_ir++;

`ifdef ILLEGAL_TRAP_EN
        fetch_decode("ill", 32'h0000_007F);
        step("ill:T", ST_TRAP, C_IDLE, 1'b1);
        bus.imem_ready = 1'b1;
        step("ill:T2", ST_TRAP, C_IDLE, 1'b1);
        bus.imem_ready = 1'b0;
        rst    = 1'b1;
        exp_ir = 32'd0;
        step("ill:rst", ST_TRAP, C_IDLE);
        rst = 1'b0;
`else
        fetch_decode("ill", 32'h0000_007F);
        exp_ir++;
        fetch_decode("sltu", 32'h0020_B1B3);
        exp_ir++;
`endif

        // Reset while a store waits on the data port.
        fetch_decode("swr", 32'h0020_A023);
        step("swr:A", ST_MEM_ADDR, cv(0, 0, 0, 0, ALUOP_ADD, 1, IMM_S, 0, 0, 0, 0));
        step("swr:Mwait", ST_MEM_WR, cv(0, 0, 0, 0, ALUOP_AND, 0, IMM_I, 1, 1, 0, 0));
        rst    = 1'b1;
        exp_ir = 32'd0;
        step("swr:rst", ST_MEM_WR, C_IDLE);
        rst = 1'b0;
        step("post_rst", ST_FETCH, cv(1, 0, 0, 0, ALUOP_AND, 0, IMM_I, 0, 0, 0, 0));
        run_alu("add2", 32'h0020_81B3, 1'b0, ALUOP_ADD);
        step("final", ST_FETCH, cv(1, 0, 0, 0, ALUOP_AND, 0, IMM_I, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
